// File: rtl/fft2d_mag_peak.sv
// fft2d_mag_peak: magnitude-squared and peak search over a streamed 2D FFT frame.
// Samples arrive row-major, one per valid cycle, FFT_N*FFT_N samples per frame.
// The magnitude path is two pipeline stages.
// The peak search runs on the stage-2 output, and the result is reported once per frame.
// Optional build macro: FFT2D_PEAK_DC_EXCLUDE_EN excludes bin 0 (DC) from the peak search.
// Ports:
//   clk, reset (async, active-low)
//   din_valid, din_re, din_im      : input sample (signed 32-bit complex)
//   mag_valid, mag_out             : re^2 + im^2, two cycles after din_valid
//   peak_mag, peak_row, peak_col   : peak of the last completed frame
//   frame_done                     : one-cycle pulse when peak_* update
//   busy                           : a frame is partially accumulated
module fft2d_mag_peak #(
   parameter int unsigned FFT_N = 32,
   localparam int unsigned RC_W = $clog2(FFT_N)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            din_valid,
   input  logic [31:0]     din_re,
   input  logic [31:0]     din_im,
   output logic            mag_valid,
   output logic [63:0]     mag_out,
   output logic [63:0]     peak_mag,
   output logic [RC_W-1:0] peak_row,
   output logic [RC_W-1:0] peak_col,
   output logic            frame_done,
   output logic            busy
);

   localparam int unsigned IDX_W = 2 * RC_W;
   localparam logic [IDX_W-1:0] LAST_IDX = '1;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t            state_q, state_d;
   logic              v1_q, v1_d;
   logic signed [63:0] rr_q, rr_d, ii_q, ii_d;
   logic signed [63:0] re_x, im_x;
   logic              mag_valid_q, mag_valid_d;
   logic [63:0]       mag_q, mag_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic [63:0]       max_q, max_d;
   logic [IDX_W-1:0]  max_idx_q, max_idx_d;
   logic [63:0]       peak_mag_q, peak_mag_d;
   logic [IDX_W-1:0]  peak_idx_q, peak_idx_d;
   logic              frame_done_q, frame_done_d;
   logic              busy_q, busy_d;
   logic              last_c;

   // Magnitude pipeline, sample counter and running maximum
   always_comb begin
      re_x        = 64'($signed(din_re));
      im_x        = 64'($signed(din_im));
      v1_d        = din_valid;
      rr_d        = rr_q;
      ii_d        = ii_q;
      mag_valid_d = v1_q;
      mag_d       = mag_q;
      cnt_d       = cnt_q;
      max_d       = max_q;
      max_idx_d   = max_idx_q;
      if (din_valid) begin
         rr_d = re_x * re_x;
         ii_d = im_x * im_x;
      end
      // Both squares are non-negative, so the unsigned sum peaks at exactly 2^63
      if (v1_q) begin
         mag_d = 64'($unsigned(rr_q)) + 64'($unsigned(ii_q));
      end
      if (mag_valid_q) begin
         // Counter wraps naturally at the frame length (power-of-two side)
         cnt_d = cnt_q + IDX_W'(1);
         if (cnt_q == '0) begin
`ifdef FFT2D_PEAK_DC_EXCLUDE_EN
            max_d = '0;
`else
            max_d = mag_q;
`endif
            max_idx_d = '0;
         end else if (mag_q > max_q) begin
            max_d     = mag_q;
            max_idx_d = cnt_q;
         end
      end
   end

   assign last_c = mag_valid_q && (cnt_q == LAST_IDX);

   // Frame FSM and peak reporting
   always_comb begin
      state_d      = state_q;
      peak_mag_d   = peak_mag_q;
      peak_idx_d   = peak_idx_q;
      frame_done_d = 1'b0;
      case (state_q)
         IDLE:    if (mag_valid_q) state_d = ACCUM;
         ACCUM:   if (last_c) state_d = DONE;
         DONE:    state_d = mag_valid_q ? ACCUM : IDLE;
         default: state_d = IDLE;
      endcase
      if (last_c) begin
         peak_mag_d   = max_d;
         peak_idx_d   = max_idx_d;
         frame_done_d = 1'b1;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         v1_q         <= 1'b0;
         rr_q         <= '0;
         ii_q         <= '0;
         mag_valid_q  <= 1'b0;
         mag_q        <= '0;
         cnt_q        <= '0;
         max_q        <= '0;
         max_idx_q    <= '0;
         peak_mag_q   <= '0;
         peak_idx_q   <= '0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         v1_q         <= v1_d;
         rr_q         <= rr_d;
         ii_q         <= ii_d;
         mag_valid_q  <= mag_valid_d;
         mag_q        <= mag_d;
         cnt_q        <= cnt_d;
         max_q        <= max_d;
         max_idx_q    <= max_idx_d;
         peak_mag_q   <= peak_mag_d;
         peak_idx_q   <= peak_idx_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign mag_valid  = mag_valid_q;
   assign mag_out    = mag_q;
   assign peak_mag   = peak_mag_q;
   assign peak_row   = peak_idx_q[IDX_W-1:RC_W];
   assign peak_col   = peak_idx_q[RC_W-1:0];
   assign frame_done = frame_done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_fft2d_mag_peak.sv
// tb_fft2d_mag_peak: directed self-checking bench for fft2d_mag_peak (FFT_N = 32).
module tb_fft2d_mag_peak;

   localparam int unsigned FFT_N = 32;
   localparam int unsigned NS    = FFT_N * FFT_N;

   logic        clk = 1'b0;
   logic        reset;
   logic        din_valid;
   logic [31:0] din_re, din_im;
   logic        mag_valid;
   logic [63:0] mag_out, peak_mag;
   logic [4:0]  peak_row, peak_col;
   logic        frame_done, busy;

   int n_total = 0;
   int n_bad   = 0;
   logic [63:0] cyc = '0;

   typedef struct {
      logic [63:0] at;
      logic [63:0] mag;
      logic [63:0] row;
      logic [63:0] col;
   } ev_t;
   ev_t evq[$];
   ev_t e0, e1;

   fft2d_mag_peak #(.FFT_N(FFT_N)) dut (
      .clk(clk), .reset(reset), .din_valid(din_valid), .din_re(din_re), .din_im(din_im),
      .mag_valid(mag_valid), .mag_out(mag_out), .peak_mag(peak_mag),
      .peak_row(peak_row), .peak_col(peak_col), .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 64'd1;

   // Record every frame_done pulse with the reported peak
   always @(negedge clk) begin
      if (frame_done) begin
         evq.push_back('{at: cyc, mag: peak_mag, row: 64'(peak_row), col: 64'(peak_col)});
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // One isolated sample; checks latency, value and hold
   task automatic one_sample(input logic [31:0] re, input logic [31:0] im, input logic [63:0] exp,
                             input string tag);
      @(negedge clk);
      din_valid = 1'b1; din_re = re; din_im = im;
      @(negedge clk);
      din_valid = 1'b0; din_re = '0; din_im = '0;
      chk({tag, "_lat1"}, 64'(mag_valid), 64'd0);
      @(negedge clk);
      chk({tag, "_vld"}, 64'(mag_valid), 64'd1);
      chk({tag, "_mag"}, mag_out, exp);
      @(negedge clk);
      chk({tag, "_vld_off"}, 64'(mag_valid), 64'd0);
      chk({tag, "_hold"}, mag_out, exp);
   endtask

   // Stream n samples of re-only data, nonzero at i1/i2; leaves din_valid high
   task automatic send_frame(input int n, input int i1, input int r1, input int i2, input int r2,
                             input bit gaps);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         din_valid = 1'b1;
         din_re    = (k == i1) ? 32'(r1) : (k == i2) ? 32'(r2) : 32'd0;
         din_im    = '0;
         if (gaps) begin
            @(negedge clk);
            din_valid = 1'b0;
         end
      end
   endtask

   task automatic end_stream();
      @(negedge clk);
      din_valid = 1'b0; din_re = '0; din_im = '0;
   endtask

   task automatic wait_events(input int n, input string tag);
      for (int i = 0; i < 20 && evq.size() < n; i++) @(negedge clk);
      chk({tag, "_count"}, 64'(evq.size()), 64'(n));
   endtask

   task automatic chk_peak(input string tag, input logic [63:0] m, input logic [63:0] r,
                           input logic [63:0] c);
      if (evq.size() > 0) begin
         e0 = evq.pop_front();
         chk({tag, "_mag"}, e0.mag, m);
         chk({tag, "_row"}, e0.row, r);
         chk({tag, "_col"}, e0.col, c);
      end else begin
         chk({tag, "_missing"}, 64'd0, 64'd1);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mag_valid"}, 64'(mag_valid), 64'd0);
      chk({tag, "_mag_out"}, mag_out, 64'd0);
      chk({tag, "_peak_mag"}, peak_mag, 64'd0);
      chk({tag, "_peak_row"}, 64'(peak_row), 64'd0);
      chk({tag, "_peak_col"}, 64'(peak_col), 64'd0);
      chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      reset = 1'b0; din_valid = 1'b0; din_re = '0; din_im = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("rst");
      reset = 1'b1;

      // Single-sample latency and extremes (these form a partial frame, discarded below)
      one_sample(32'd3, 32'hFFFF_FFFC, 64'd25, "s25");
      chk("busy_partial", 64'(busy), 64'd1);
      one_sample(32'h8000_0000, 32'h8000_0000, 64'h8000_0000_0000_0000, "ext_min");
      one_sample(32'h7FFF_FFFF, 32'd0, 64'h3FFF_FFFF_0000_0001, "ext_max");
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;
      chk("busy_after_rst", 64'(busy), 64'd0);

      // Single peak at index 37
      evq.delete();
      send_frame(NS, 37, 100, -1, 0, 1'b0);
      end_stream();
      wait_events(1, "peak37");
      chk_peak("peak37", 64'd10000, 64'd1, 64'd5);
      chk("idle_busy", 64'(busy), 64'd0);

      // Ties keep the earliest index, contiguous and gapped input
      send_frame(NS, 10, 7, 900, 7, 1'b0);
      end_stream();
      wait_events(1, "tie");
      chk_peak("tie", 64'd49, 64'd0, 64'd10);
      send_frame(NS, 10, 7, 900, 7, 1'b1);
      end_stream();
      wait_events(1, "tie_gap");
      chk_peak("tie_gap", 64'd49, 64'd0, 64'd10);

      // Back-to-back frames with no dead cycle
      send_frame(NS, 0, 50, -1, 0, 1'b0);
      send_frame(NS, 1023, 60, -1, 0, 1'b0);
      end_stream();
      wait_events(2, "b2b");
      if (evq.size() >= 2) begin
         e1 = evq[1];
         chk("b2b_spacing", e1.at - evq[0].at, 64'(NS));
      end
`ifdef FFT2D_PEAK_DC_EXCLUDE_EN
      chk_peak("b2b_f0", 64'd0, 64'd0, 64'd0);
`else
      chk_peak("b2b_f0", 64'd2500, 64'd0, 64'd0);
`endif
      chk_peak("b2b_f1", 64'd3600, 64'd31, 64'd31);

      // Mid-frame reset discards the partial frame
      evq.delete();
      send_frame(500, 5, 20, -1, 0, 1'b0);
      @(negedge clk);
      reset = 1'b0; din_valid = 1'b0; din_re = '0;
      #1;
      chk_all_zero("midrst");
      repeat (4) @(negedge clk);
      chk("midrst_no_done", 64'(evq.size()), 64'd0);
      reset = 1'b1;
      send_frame(NS, 33, 9, -1, 0, 1'b0);
      end_stream();
      wait_events(1, "post_rst");
      chk_peak("post_rst", 64'd81, 64'd1, 64'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/fft2d_mag_peak.md
FFT2D_MAG_PEAK -- requirements
Module: fft2d_mag_peak

Interface
REQ-001 The module SHALL have parameter FFT_N, default 32, meaning the transform side length; frame length is FFT_N*FFT_N samples, and FFT_N SHALL be a power of two from 4 to 64.
REQ-002 The module SHALL have port clk, input, width 1: rising-edge clock.
REQ-003 The module SHALL have port reset, input, width 1: asynchronous, active-low reset.
REQ-004 The module SHALL have port din_valid, input, width 1: qualifies din_re and din_im for one sample per cycle.
REQ-005 The module SHALL have port din_re, input, width 32: signed two's-complement real part of the 2D FFT output.
REQ-006 The module SHALL have port din_im, input, width 32: signed two's-complement imaginary part.
REQ-007 The module SHALL have port mag_valid, output, width 1: qualifies mag_out.
REQ-008 The module SHALL have port mag_out, output, width 64: unsigned din_re^2 + din_im^2.
REQ-009 The module SHALL have port peak_mag, output, width 64: largest magnitude in the last completed frame.
REQ-010 The module SHALL have port peak_row, output, width log2(FFT_N): row of the peak.
REQ-011 The module SHALL have port peak_col, output, width log2(FFT_N): column of the peak.
REQ-012 The module SHALL have port frame_done, output, width 1: one-cycle pulse when peak_* update.
REQ-013 The module SHALL have port busy, output, width 1: high while a frame is partially accumulated.

Function
REQ-014 Sample k of a frame (k = 0 .. FFT_N*FFT_N-1, counting accepted din_valid cycles only) SHALL map to row = k / FFT_N and col = k mod FFT_N.
REQ-015 The magnitude path SHALL be a 2-stage pipeline: stage 1 registers the full-precision signed products re*re and im*im; stage 2 registers their unsigned 64-bit sum.
REQ-016 mag_valid SHALL equal din_valid delayed by exactly 2 cycles, and mag_out SHALL be held between valid cycles.
REQ-017 Gaps in din_valid SHALL be allowed at any point, with no loss of samples and no change to the index mapping.
REQ-018 The state machine SHALL have three states:
- IDLE: entered on reset; moves to ACCUM on the first stage-2 valid.
- ACCUM: moves to DONE on the stage-2 valid of index FFT_N*FFT_N-1.
- DONE: lasts one cycle; returns to IDLE, or to ACCUM if a stage-2 valid is present that cycle.
REQ-019 The running maximum SHALL update only when a new magnitude is strictly greater than it, so ties keep the earliest index.
REQ-020 The running maximum SHALL be reinitialised by the index-0 sample of each frame, taking that sample's value unconditionally.
REQ-021 peak_mag, peak_row and peak_col SHALL update together in the cycle after the last sample's stage-2 valid, and SHALL hold until the next frame completes.
REQ-022 frame_done SHALL pulse high for one cycle coincident with that update.
REQ-023 A sample arriving in the DONE cycle SHALL be index 0 of the next frame; back-to-back frames SHALL be processed with zero dead cycles.
REQ-024 busy SHALL be high from the first stage-2 valid of a frame until frame_done, inclusive.
REQ-025 The worst case, re = im = -2^31, SHALL produce 2^63 without overflow.

Reset
REQ-026 reset low SHALL asynchronously clear the pipeline, sample counter, running maximum and state (to IDLE).
REQ-027 reset low SHALL clear all outputs: mag_valid=0, mag_out=0, peak_mag=0, peak_row=0, peak_col=0, frame_done=0, busy=0.
REQ-028 A reset asserted mid-frame SHALL discard the partial frame; the first valid sample after reset release SHALL be index 0.

Configuration
REQ-029 The macro FFT2D_PEAK_DC_EXCLUDE_EN SHALL control DC-bin handling.
- When FFT2D_PEAK_DC_EXCLUDE_EN is defined, index 0 (DC) SHALL be excluded from the peak search; the running maximum SHALL be reinitialised to 0 at index 0, and a frame whose only nonzero bin is DC SHALL report peak_mag=0, row=0, col=0.
- When FFT2D_PEAK_DC_EXCLUDE_EN is undefined, DC SHALL be treated like any other bin.
- mag_out SHALL be identical in both builds.

Verification
REQ-030 Single sample: din_re=3, din_im=-4 with din_valid for 1 cycle -> mag_valid exactly 2 cycles later with mag_out=25.
REQ-031 Single peak: a frame of 1024 samples, all zero except index 37 (re=100, im=0) -> frame_done pulse with peak_mag=10000, peak_row=1, peak_col=5.
REQ-032 Ties: equal maxima (re=7) at indices 10 and 900 -> peak_row=0, peak_col=10; with din_valid toggling every other cycle -> identical result.
REQ-033 Back-to-back frames: two frames streamed with no gap, peak at index 0 (value 50) then index 1023 (value 60) -> two frame_done pulses 1024 cycles apart.
- Without the macro: first pulse reports 2500 at row 0, col 0; second reports 3600 at row 31, col 31.
- With FFT2D_PEAK_DC_EXCLUDE_EN: first pulse reports peak_mag=0.
REQ-034 Mid-frame reset: reset asserted after 500 samples -> all outputs 0 immediately, with no frame_done; a following full frame -> correct peak with index 0 at the first post-reset sample.
REQ-035 Extremes: re=im=-2^31 -> mag_out=2^63; re=2^31-1, im=0 -> mag_out=(2^31-1)^2.
